// File: rtl/state_main.sv
// rtl/state_main.sv - top-level main-state FSM: idle, operand load, execute, done
module state_main (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       load,
    input  logic       fin,
    output logic [2:0] q
);

    // Shared main-state codes; downstream logic decodes q against these values.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EXEC = 3'd2,
        S_DONE = 3'd3
    } main_state_t;

    main_state_t state;
    main_state_t state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Each state looks only at its own qualifying input.
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:  state_next = run  ? S_LOAD : S_IDLE;
            S_LOAD:  state_next = load ? S_EXEC : S_LOAD;
            S_EXEC:  state_next = fin  ? S_DONE : S_EXEC;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign q = state;

endmodule

// File: tb/tb_state_main.sv
// tb/tb_state_main.sv - self-checking bench for state_main
module tb_state_main;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       load;
    logic       fin;
    logic [2:0] q;

    int vectors;
    int fails;

    typedef struct {
        logic       run;
        logic       load;
        logic       fin;
        logic [2:0] exp_q;
    } vec_t;

    vec_t table_q[$];

    state_main dut (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .load (load),
        .fin  (fin),
        .q    (q)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: q=%0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic r, input logic l, input logic f, input logic [2:0] e);
        vec_t v;
        v.run = r; v.load = l; v.fin = f; v.exp_q = e;
        table_q.push_back(v);
    endfunction

    // Reference: operation stage 0..3; each stage needs one particular input
    // (stage 3 needs none) to advance to the next stage modulo 4.
    function automatic int model_next(input int stage, input logic r, input logic l, input logic f);
        logic need[4];
        need[0] = r; need[1] = l; need[2] = f; need[3] = 1'b1;
        return need[stage] ? (stage + 1) % 4 : stage;
    endfunction

    int stage;

    initial begin
        vectors = 0;
        fails   = 0;
        rst_n = 1'b0; run = 1'b0; load = 1'b0; fin = 1'b0;

        #120;
        check("reset_hold", q, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        add(0, 0, 0, 0);
        add(0, 0, 0, 0);
        add(1, 0, 0, 1);
        add(0, 0, 0, 1);
        add(0, 1, 0, 2);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 2);
        add(0, 0, 1, 3);
        add(1, 1, 1, 0);
        add(1, 1, 1, 1);
        add(1, 1, 1, 2);
        add(1, 1, 1, 3);
        add(1, 1, 1, 0);
        add(0, 1, 1, 0);
        add(0, 1, 1, 0);
        add(1, 0, 1, 1);
        add(0, 0, 1, 1);
        add(0, 0, 1, 1);
        add(0, 1, 0, 2);

        foreach (table_q[i]) begin
            run  = table_q[i].run;
            load = table_q[i].load;
            fin  = table_q[i].fin;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("table[%0d]", i), q, table_q[i].exp_q);
        end

        // Asynchronous reset between edges while in EXEC.
        run = 1'b0; load = 1'b0; fin = 1'b0;
        @(posedge clk);
        #10 check("exec_before_reset", q, 3'd2);
        #20 rst_n = 1'b0;
        #5  check("async_reset", q, 3'd0);
        #5  rst_n = 1'b1;
        @(negedge clk);
        check("after_release_1", q, 3'd0);
        @(negedge clk);
        check("after_release_2", q, 3'd0);

        // Randomized run against the stage model, with occasional reset pulses.
        stage = 0;
        for (int n = 0; n < 400; n++) begin
            check($sformatf("rand[%0d]", n), q, stage[2:0]);
            if ($urandom_range(0, 49) == 0) begin
                #10 rst_n = 1'b0;
                #5  check($sformatf("rand_reset[%0d]", n), q, 3'd0);
                rst_n = 1'b1;
                stage = 0;
            end
            run  = ($urandom_range(0, 2) == 0);
            load = ($urandom_range(0, 2) == 0);
            fin  = ($urandom_range(0, 2) == 0);
            stage = model_next(stage, run, load, fin);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/state_main.md
Name: state_main

Overview:
- Top-level control FSM of the accelerator.
- Sequences one operation: idle → wait for operand load → execute → done → idle.
- Outputs its current state code on q, which downstream datapath/sub-FSMs decode.
- State codes are the shared main-state constants in the project's state-definition include; this block uses those values exactly.

Parameters:
- none (state encodings are fixed constants, listed below)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- run  input  1  start request; level-sensitive, sampled in IDLE only
- load  input  1  operand-load-complete indication; sampled in LOAD only
- fin  input  1  execution-complete indication; sampled in EXEC only
- q  output  3  current main state code

Behaviour:
Interface:
- One clock, clk.
- Reset is asynchronous and active-low on rst_n.

State encoding (q values):
- IDLE=3'd0
- LOAD=3'd1
- EXEC=3'd2
- DONE=3'd3
- Codes 3'd4–3'd7 are unused.

Reset and output timing:
- rst_n=0 forces the state to IDLE immediately (asynchronous), independent of clk.
- q=3'd0 while rst_n is low.
- Moore machine: q is the state register itself.
  - No combinational path from run/load/fin to q.
  - q changes only on a rising clk edge or on reset assertion.

Transitions (evaluated at each rising clk edge, rst_n=1):
- IDLE: run=1 → LOAD; otherwise stay.
- LOAD: load=1 → EXEC; otherwise stay.
- EXEC: fin=1 → DONE; otherwise stay.
- DONE: unconditionally → IDLE after exactly one cycle.
- Unused codes 4–7: next state IDLE (recovery). These codes are unreachable in normal operation.

Input sampling:
- Each input is ignored in every state other than the one listed.
  - Example: load=1 in IDLE does not skip LOAD.
  - Example: fin=1 in LOAD does not skip EXEC.
- Inputs are levels, not pulses. If a level is held high, the FSM advances one state per cycle.
  - With run, load and fin all held at 1, the sequence is IDLE→LOAD→EXEC→DONE→IDLE→LOAD…, a 4-cycle loop.

Latency:
- Each transition takes effect at the first rising edge at which the qualifying input is 1.
- Minimum full operation is 4 cycles (IDLE→IDLE).

Simultaneous events and reset:
- Only the input relevant to the current state matters, so there is no priority conflict.
- Reset mid-operation (any state) returns to IDLE asynchronously.
- After release, the FSM waits for run again; there is no resumption.

Test Plan:
Clock period is 100 time units.
1. Reset: rst_n=0 with run=load=fin=0 → q=0. Release rst_n with inputs low for 2 cycles → q stays 0.
2. Start: run=1 at an edge-aligned time → q=1 after the next rising edge. Keep load=0 for 1 cycle → q stays 1.
3. Load/exec: load=1 → q=2 next edge. Hold fin=0 for 10 cycles → q stays 2.
4. Finish: fin=1 → q=3 for exactly one cycle, then q=0. With run/load/fin all still 1, q continues 1,2,3,0,1… every cycle.
5. Ignored inputs: in IDLE with run=0, assert load=1 and fin=1 → q remains 0. In LOAD with load=0, fin=1 → q remains 1.
6. Async reset mid-run: in EXEC (q=2), pulse rst_n low between clock edges → q=0 immediately without a clock edge. After release with run=0 → q stays 0.
